// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store front-end for main_memory.
// Sequences the mem_read/mem_write strobes, owns the shared data bus drive,
// captures load data and rejects addresses the memory cannot service.
module mem_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_e;

  // One extra bit so DEPTH itself is representable for the bound compare.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              addr_legal;

  assign addr_legal = (req_addr != '0) && ({1'b0, req_addr} < DEPTH_L);

  // Strobes and bus drive decode straight from state so a reset drops them
  // in the very next cycle.
  assign req_ready  = (state_q == IDLE);
  assign mem_write  = (state_q == WRITE);
  assign mem_read   = (state_q == READ);
  assign mem_addr   = addr_q;
  assign mem_data   = (state_q == WRITE) ? wdata_q : {DATA_W{1'bz}};
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

  // Next-state, request capture and load-data capture.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    // Response flags are registered off the RESP state, so they appear the
    // cycle after RESP (store: after edge 2, load: edge 3, error: edge 1).
    resp_valid_d = (state_q == RESP);
    resp_err_d   = (state_q == RESP) && err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = !addr_legal;
          if (!addr_legal)  state_d = RESP;
          else if (req_we)  state_d = WRITE;
          else              state_d = READ;
        end
      end
      WRITE:   state_d = RESP;
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        // main_memory presents its data register on the bus this cycle.
        rdata_d = mem_data;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small main_memory model.
// When neither side should drive the bus, a keeper drives PROBE so that any
// stray drive by the unit shows up as a value other than PROBE.
module tb_mem_access_unit;
  localparam logic [15:0] PROBE = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [15:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr;
  wire  [15:0] mem_data;

  logic [15:0] mem [0:1023];
  logic [15:0] mem_dout = '0;
  logic        mem_oe = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory drives its data register the cycle after a read strobe; keeper
  // drives PROBE whenever the unit should have the bus released.
  assign mem_data = mem_oe ? mem_dout : (mem_write ? 16'hzzzz : PROBE);

  // main_memory model: preloaded words during reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[3] <= 16'h5555;
      mem[7] <= 16'h7777;
      mem_oe <= 1'b0;
    end else begin
      if (mem_write) mem[mem_addr[9:0]] <= mem_data;
      if (mem_read)  mem_dout <= mem[mem_addr[9:0]];
      mem_oe <= mem_read;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request; lat = cycles from accept edge to resp_valid (negated if the
  // pulse lasts more than one cycle, 0 if it never comes).
  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic err, output logic [15:0] rd,
                        output int nwr, output int nrd, output int nbad,
                        output logic [15:0] wa, output logic [15:0] wd);
    lat = 0; err = 1'b0; rd = '0; nwr = 0; nrd = 0; nbad = 0; wa = '0; wd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_write) begin nwr++; wa = mem_addr; wd = mem_data; end
      if (mem_read) begin nrd++; if (mem_data !== PROBE) nbad++; end
      if (mem_read && mem_write) nbad++;
      if (resp_valid) begin lat = i; err = resp_err; rd = resp_rdata; break; end
    end
    @(negedge clk);
    if (resp_valid) lat = -lat;
  endtask

  int          lat, nwr, nrd, nbad, nacc, ncomp, nerr, idx, rv_seen;
  int          acc_cyc [3];
  logic        err, acc;
  logic [15:0] rd, wa, wd, last_rd;
  logic        q_we [3];
  logic [15:0] q_addr [3];
  logic [15:0] q_data [3];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_valid", {31'b0, resp_valid}, 0);
    chk("rst_err", {31'b0, resp_err}, 0);
    chk("rst_rdata", {16'b0, resp_rdata}, 0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
    chk("rst_addr", {16'b0, mem_addr}, 0);
    chk("rst_bus_z", {16'b0, mem_data}, {16'b0, PROBE});

    // Store 0xBEEF to 5.
    do_req(1'b1, 16'd5, 16'hBEEF, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("st5_lat", lat, 3);
    chk("st5_err", {31'b0, err}, 0);
    chk("st5_nwr", nwr, 1);
    chk("st5_nrd", nrd, 0);
    chk("st5_waddr", {16'b0, wa}, 5);
    chk("st5_wdata", {16'b0, wd}, 16'hBEEF);
    chk("st5_bus_z", {16'b0, mem_data}, {16'b0, PROBE});

    // Load 5 back.
    do_req(1'b0, 16'd5, 16'h0, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("ld5_lat", lat, 4);
    chk("ld5_err", {31'b0, err}, 0);
    chk("ld5_rdata", {16'b0, rd}, 16'hBEEF);
    chk("ld5_nrd", nrd, 1);
    chk("ld5_nwr", nwr, 0);
    chk("ld5_bus", nbad, 0);

    // Illegal addresses: 0, DEPTH, 0xFFFF.
    do_req(1'b1, 16'd0, 16'h1234, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("st0_lat", lat, 2);
    chk("st0_err", {31'b0, err}, 1);
    chk("st0_strobes", nwr + nrd, 0);
    chk("st0_rdata", {16'b0, rd}, 16'hBEEF);
    do_req(1'b0, 16'd1024, 16'h0, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("ld1024_lat", lat, 2);
    chk("ld1024_err", {31'b0, err}, 1);
    chk("ld1024_strobes", nwr + nrd, 0);
    chk("ld1024_rdata", {16'b0, rd}, 16'hBEEF);
    do_req(1'b0, 16'hFFFF, 16'h0, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("ldffff_err", {31'b0, err}, 1);
    chk("ldffff_strobes", nwr + nrd, 0);
    chk("err_cleared", {31'b0, resp_err}, 0);

    // Top legal address.
    do_req(1'b1, 16'd1023, 16'h00FF, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("st1023_err", {31'b0, err}, 0);
    chk("st1023_waddr", {16'b0, wa}, 1023);
    do_req(1'b0, 16'd1023, 16'h0, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("ld1023_err", {31'b0, err}, 0);
    chk("ld1023_rdata", {16'b0, rd}, 16'h00FF);

    // Three queued requests with req_valid held throughout.
    q_we[0] = 1'b1; q_addr[0] = 16'd10; q_data[0] = 16'h1111;
    q_we[1] = 1'b1; q_addr[1] = 16'd11; q_data[1] = 16'h2222;
    q_we[2] = 1'b0; q_addr[2] = 16'd10; q_data[2] = 16'h0000;
    idx = 0; nacc = 0; ncomp = 0; nerr = 0; last_rd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = q_we[0]; req_addr = q_addr[0]; req_wdata = q_data[0];
    for (int c = 0; c < 40 && ncomp < 3; c++) begin
      acc = req_valid && req_ready;
      if (resp_valid) begin ncomp++; if (resp_err) nerr++; last_rd = resp_rdata; end
      if (acc) begin if (nacc < 3) acc_cyc[nacc] = c; nacc++; end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin req_we = q_we[idx]; req_addr = q_addr[idx]; req_wdata = q_data[idx]; end
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("q_accepts", nacc, 3);
    chk("q_completions", ncomp, 3);
    chk("q_gap01", acc_cyc[1] - acc_cyc[0], 3);
    chk("q_gap12", acc_cyc[2] - acc_cyc[1], 3);
    chk("q_errs", nerr, 0);
    chk("q_rdata", {16'b0, last_rd}, 16'h1111);
    chk("q_mem11", {16'b0, mem[11]}, 16'h2222);

    // Reset during the READ cycle of a load from 7.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    chk("rst_in_read", {31'b0, mem_read}, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {30'b0, mem_read, mem_write}, 0);
    chk("abort_bus_z", {16'b0, mem_data}, {16'b0, PROBE});
    chk("abort_ready", {31'b0, req_ready}, 1);
    rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) rv_seen++;
      @(negedge clk);
    end
    chk("abort_no_resp", rv_seen, 0);
    do_req(1'b0, 16'd7, 16'h0, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("ld7_lat", lat, 4);
    chk("ld7_rdata", {16'b0, rd}, 16'h7777);

    // resp_rdata only follows loads.
    do_req(1'b1, 16'd2, 16'hAAAA, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("st2_mem", {16'b0, mem[2]}, 16'hAAAA);
    do_req(1'b0, 16'd3, 16'h0, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("ld3_rdata", {16'b0, rd}, 16'h5555);
    do_req(1'b1, 16'd4, 16'h9999, lat, err, rd, nwr, nrd, nbad, wa, wd);
    chk("st4_rdata_held", {16'b0, rd}, 16'h5555);
    chk("st4_rdata_after", {16'b0, resp_rdata}, 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
